// File: rtl/uart_fifo_transceiver.sv
// UART transceiver with a small FIFO on each direction.
// TX: FIFO -> serialiser (start, data LSB first, optional even parity, stop).
// RX: 2-flop synchroniser -> mid-bit sampler -> FIFO with show-ahead head,
//     per-entry frame/parity error flags and a sticky overrun flag.
module uart_fifo_transceiver #(
  parameter logic [27:0] CLOCK_FREQ = 28'd100000000,
  parameter int          DATA_BITS  = 8,
  parameter int          PARITY_EN  = 0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                 clk_int,
  input  logic                 uart_reset,
  input  logic [1:0]           freq_control,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_wr,
  output logic                 tx_full,
  output logic                 tx_busy,
  output logic                 uart_tx_d_out,
  input  logic                 uart_rx_d_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  input  logic                 rx_rd,
  output logic                 rx_empty,
  output logic                 rx_overrun,
  input  logic                 rx_clr_ovr
);

  // Bit periods in clock cycles for each selectable baud rate.
  localparam int unsigned DIV_9600   = CLOCK_FREQ / 28'd9600;
  localparam int unsigned DIV_19200  = CLOCK_FREQ / 28'd19200;
  localparam int unsigned DIV_57600  = CLOCK_FREQ / 28'd57600;
  localparam int unsigned DIV_115200 = CLOCK_FREQ / 28'd115200;
  localparam int          CNT_W      = $clog2(DIV_9600 + 1);

  localparam int              PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam int              ENTRY_W  = DATA_BITS + 2;
  localparam logic [3:0]      LAST_IDX = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  logic [CNT_W-1:0] w_div_sel;

  // Map the baud selector onto a bit period; engines latch this at frame start.
  always_comb begin
    w_div_sel = CNT_W'(DIV_9600);
    case (freq_control)
      2'b00:   w_div_sel = CNT_W'(DIV_9600);
      2'b01:   w_div_sel = CNT_W'(DIV_19200);
      2'b10:   w_div_sel = CNT_W'(DIV_57600);
      default: w_div_sel = CNT_W'(DIV_115200);
    endcase
  end

  // ---------------------------------------------------------------- TX FIFO
  logic [DATA_BITS-1:0] r_tx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_tx_wr_ptr;
  logic [PTR_W-1:0]     r_tx_rd_ptr;
  logic [PTR_W:0]       r_tx_count;
  logic                 w_tx_empty;
  logic                 w_tx_push;
  logic                 w_tx_pop;
  logic [DATA_BITS-1:0] w_tx_head;

  assign w_tx_empty = (r_tx_count == '0);
  assign tx_full    = (r_tx_count == FULL_CNT);
  assign w_tx_push  = tx_wr && !tx_full;
  assign w_tx_head  = r_tx_mem[r_tx_rd_ptr];

  // TX storage array; written only on an accepted push.
  always_ff @(posedge clk_int) begin
    if (w_tx_push) begin
      r_tx_mem[r_tx_wr_ptr] <= tx_data;
    end
  end

  // TX FIFO pointers and occupancy.
  always_ff @(posedge clk_int) begin
    if (uart_reset) begin
      r_tx_wr_ptr <= '0;
      r_tx_rd_ptr <= '0;
      r_tx_count  <= '0;
    end else begin
      if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + 1'b1;
      if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + 1'b1;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_count <= r_tx_count + 1'b1;
        2'b01:   r_tx_count <= r_tx_count - 1'b1;
        default: r_tx_count <= r_tx_count;
      endcase
    end
  end

  // ---------------------------------------------------------------- TX engine
  tx_state_t            r_tx_state, w_tx_state_next;
  logic [CNT_W-1:0]     r_tx_cnt, w_tx_cnt_next;
  logic [CNT_W-1:0]     r_tx_div, w_tx_div_next;
  logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_next;
  logic [3:0]           r_tx_idx, w_tx_idx_next;
  logic                 r_tx_par, w_tx_par_next;
  logic                 r_tx_out, w_tx_out_next;
  logic                 w_tx_load;
  logic                 w_tx_bit_end;

  assign w_tx_bit_end  = (r_tx_cnt == r_tx_div - CNT_W'(1));
  assign w_tx_pop      = w_tx_load;
  assign uart_tx_d_out = r_tx_out;
  assign tx_busy       = !w_tx_empty || (r_tx_state != TX_IDLE);

  // TX state register; the line itself is a register so it is glitch-free.
  always_ff @(posedge clk_int) begin
    if (uart_reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_div   <= '0;
      r_tx_shift <= '0;
      r_tx_idx   <= '0;
      r_tx_par   <= 1'b0;
      r_tx_out   <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_next;
      r_tx_cnt   <= w_tx_cnt_next;
      r_tx_div   <= w_tx_div_next;
      r_tx_shift <= w_tx_shift_next;
      r_tx_idx   <= w_tx_idx_next;
      r_tx_par   <= w_tx_par_next;
      r_tx_out   <= w_tx_out_next;
    end
  end

  // TX next state: count DIV cycles per bit; load straight from STOP for back-to-back frames.
  always_comb begin
    w_tx_state_next = r_tx_state;
    w_tx_cnt_next   = r_tx_cnt + CNT_W'(1);
    w_tx_div_next   = r_tx_div;
    w_tx_shift_next = r_tx_shift;
    w_tx_idx_next   = r_tx_idx;
    w_tx_par_next   = r_tx_par;
    w_tx_out_next   = r_tx_out;
    w_tx_load       = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_cnt_next = '0;
        w_tx_out_next = 1'b1;
        if (!w_tx_empty) w_tx_load = 1'b1;
      end
      TX_START: begin
        if (w_tx_bit_end) begin
          w_tx_cnt_next   = '0;
          w_tx_idx_next   = '0;
          w_tx_out_next   = r_tx_shift[0];
          w_tx_state_next = TX_DATA;
        end
      end
      TX_DATA: begin
        if (w_tx_bit_end) begin
          w_tx_cnt_next = '0;
          if (r_tx_idx == LAST_IDX) begin
            if (PARITY_EN != 0) begin
              w_tx_out_next   = r_tx_par;
              w_tx_state_next = TX_PARITY;
            end else begin
              w_tx_out_next   = 1'b1;
              w_tx_state_next = TX_STOP;
            end
          end else begin
            w_tx_idx_next   = r_tx_idx + 4'd1;
            w_tx_shift_next = r_tx_shift >> 1;
            w_tx_out_next   = r_tx_shift[1];
          end
        end
      end
      TX_PARITY: begin
        if (w_tx_bit_end) begin
          w_tx_cnt_next   = '0;
          w_tx_out_next   = 1'b1;
          w_tx_state_next = TX_STOP;
        end
      end
      TX_STOP: begin
        if (w_tx_bit_end) begin
          w_tx_cnt_next = '0;
          if (!w_tx_empty) begin
            w_tx_load = 1'b1;
          end else begin
            w_tx_out_next   = 1'b1;
            w_tx_state_next = TX_IDLE;
          end
        end
      end
      default: begin
        w_tx_out_next   = 1'b1;
        w_tx_state_next = TX_IDLE;
      end
    endcase
    if (w_tx_load) begin
      w_tx_state_next = TX_START;
      w_tx_cnt_next   = '0;
      w_tx_div_next   = w_div_sel;
      w_tx_shift_next = w_tx_head;
      w_tx_par_next   = ^w_tx_head;
      w_tx_out_next   = 1'b0;
    end
  end

  // ---------------------------------------------------------------- RX engine
  logic r_rx_sync1, r_rx_sync2, r_rx_prev;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk_int) begin
    if (uart_reset) begin
      r_rx_sync1 <= 1'b1;
      r_rx_sync2 <= 1'b1;
      r_rx_prev  <= 1'b1;
    end else begin
      r_rx_sync1 <= uart_rx_d_in;
      r_rx_sync2 <= r_rx_sync1;
      r_rx_prev  <= r_rx_sync2;
    end
  end

  rx_state_t            r_rx_state, w_rx_state_next;
  logic [CNT_W-1:0]     r_rx_cnt, w_rx_cnt_next;
  logic [CNT_W-1:0]     r_rx_div, w_rx_div_next;
  logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_next;
  logic [3:0]           r_rx_idx, w_rx_idx_next;
  logic                 r_rx_par_err, w_rx_par_err_next;
  logic                 r_rx_push, w_rx_push_next;
  logic [ENTRY_W-1:0]   r_rx_entry, w_rx_entry_next;
  logic                 w_rx_bit_end;
  logic                 w_rx_half_end;

  assign w_rx_bit_end  = (r_rx_cnt == r_rx_div - CNT_W'(1));
  assign w_rx_half_end = (r_rx_cnt == (r_rx_div >> 1) - CNT_W'(1));

  // RX state register; the completed character waits one cycle in r_rx_entry.
  always_ff @(posedge clk_int) begin
    if (uart_reset) begin
      r_rx_state   <= RX_IDLE;
      r_rx_cnt     <= '0;
      r_rx_div     <= '0;
      r_rx_shift   <= '0;
      r_rx_idx     <= '0;
      r_rx_par_err <= 1'b0;
      r_rx_push    <= 1'b0;
      r_rx_entry   <= '0;
    end else begin
      r_rx_state   <= w_rx_state_next;
      r_rx_cnt     <= w_rx_cnt_next;
      r_rx_div     <= w_rx_div_next;
      r_rx_shift   <= w_rx_shift_next;
      r_rx_idx     <= w_rx_idx_next;
      r_rx_par_err <= w_rx_par_err_next;
      r_rx_push    <= w_rx_push_next;
      r_rx_entry   <= w_rx_entry_next;
    end
  end

  // RX next state: confirm start at half a bit, then sample every DIV cycles.
  always_comb begin
    w_rx_state_next   = r_rx_state;
    w_rx_cnt_next     = r_rx_cnt + CNT_W'(1);
    w_rx_div_next     = r_rx_div;
    w_rx_shift_next   = r_rx_shift;
    w_rx_idx_next     = r_rx_idx;
    w_rx_par_err_next = r_rx_par_err;
    w_rx_push_next    = 1'b0;
    w_rx_entry_next   = r_rx_entry;
    case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt_next = '0;
        if (r_rx_prev && !r_rx_sync2) begin
          w_rx_div_next     = w_div_sel;
          w_rx_par_err_next = 1'b0;
          w_rx_state_next   = RX_START;
        end
      end
      RX_START: begin
        if (w_rx_half_end) begin
          w_rx_cnt_next = '0;
          if (!r_rx_sync2) begin
            w_rx_idx_next   = '0;
            w_rx_state_next = RX_DATA;
          end else begin
            w_rx_state_next = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (w_rx_bit_end) begin
          w_rx_cnt_next   = '0;
          w_rx_shift_next = {r_rx_sync2, r_rx_shift[DATA_BITS-1:1]};
          if (r_rx_idx == LAST_IDX) begin
            w_rx_state_next = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
          end else begin
            w_rx_idx_next = r_rx_idx + 4'd1;
          end
        end
      end
      RX_PARITY: begin
        if (w_rx_bit_end) begin
          w_rx_cnt_next     = '0;
          w_rx_par_err_next = (^r_rx_shift) ^ r_rx_sync2;
          w_rx_state_next   = RX_STOP;
        end
      end
      RX_STOP: begin
        if (w_rx_bit_end) begin
          w_rx_cnt_next   = '0;
          w_rx_push_next  = 1'b1;
          w_rx_entry_next = {r_rx_shift, ~r_rx_sync2, r_rx_par_err};
          w_rx_state_next = RX_IDLE;
        end
      end
      default: w_rx_state_next = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [ENTRY_W-1:0] r_rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_rx_wr_ptr;
  logic [PTR_W-1:0]   r_rx_rd_ptr;
  logic [PTR_W:0]     r_rx_count;
  logic               r_rx_ovr;
  logic               w_rx_empty;
  logic               w_rx_full;
  logic               w_rx_pop;
  logic               w_rx_accept;
  logic               w_rx_drop;
  logic [ENTRY_W-1:0] w_rx_head;

  assign w_rx_empty  = (r_rx_count == '0);
  assign w_rx_full   = (r_rx_count == FULL_CNT);
  assign w_rx_pop    = rx_rd && !w_rx_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_rx_accept = r_rx_push && (!w_rx_full || w_rx_pop);
  assign w_rx_drop   = r_rx_push && w_rx_full && !w_rx_pop;
  assign w_rx_head   = r_rx_mem[r_rx_rd_ptr];

  assign rx_empty      = w_rx_empty;
  assign rx_overrun    = r_rx_ovr;
  assign rx_data       = w_rx_empty ? '0 : w_rx_head[ENTRY_W-1:2];
  assign rx_frame_err  = !w_rx_empty && w_rx_head[1];
  assign rx_parity_err = !w_rx_empty && w_rx_head[0];

  // RX storage array; written only when a received character is accepted.
  always_ff @(posedge clk_int) begin
    if (w_rx_accept) begin
      r_rx_mem[r_rx_wr_ptr] <= r_rx_entry;
    end
  end

  // RX FIFO pointers, occupancy and sticky overrun (a new drop beats a clear).
  always_ff @(posedge clk_int) begin
    if (uart_reset) begin
      r_rx_wr_ptr <= '0;
      r_rx_rd_ptr <= '0;
      r_rx_count  <= '0;
      r_rx_ovr    <= 1'b0;
    end else begin
      if (w_rx_accept) r_rx_wr_ptr <= r_rx_wr_ptr + 1'b1;
      if (w_rx_pop)    r_rx_rd_ptr <= r_rx_rd_ptr + 1'b1;
      case ({w_rx_accept, w_rx_pop})
        2'b10:   r_rx_count <= r_rx_count + 1'b1;
        2'b01:   r_rx_count <= r_rx_count - 1'b1;
        default: r_rx_count <= r_rx_count;
      endcase
      if (w_rx_drop)       r_rx_ovr <= 1'b1;
      else if (rx_clr_ovr) r_rx_ovr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_fifo_transceiver.sv
// Bench for uart_fifo_transceiver at DIV=10 (1.152 MHz clock, 115200 baud).
// Instance u_dut0 has no parity, u_dut1 has even parity enabled.
module tb_uart_fifo_transceiver;

  logic       clk = 1'b0;
  logic       uart_reset = 1'b0;
  logic [1:0] freq = 2'b11;
  logic       loopback = 1'b0;
  logic       line0 = 1'b1;
  logic       line1 = 1'b1;

  logic [7:0] tx_data0 = '0, tx_data1 = '0;
  logic       tx_wr0 = 1'b0, tx_wr1 = 1'b0;
  logic       tx_full0, tx_full1, tx_busy0, tx_busy1, tx_out0, tx_out1;
  logic       rx_in0;
  logic [7:0] rx_data0, rx_data1;
  logic       fe0, fe1, pe0, pe1, rx_empty0, rx_empty1, ovr0, ovr1;
  logic       rx_rd0 = 1'b0, rx_rd1 = 1'b0, clr0 = 1'b0, clr1 = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [9:0] sb0[$];
  logic [9:0] sb1[$];

  assign rx_in0 = loopback ? tx_out0 : line0;

  always #5 clk = ~clk;

  uart_fifo_transceiver #(.CLOCK_FREQ(28'd1152000), .DATA_BITS(8), .PARITY_EN(0), .FIFO_DEPTH(4)) u_dut0 (
    .clk_int(clk), .uart_reset(uart_reset), .freq_control(freq),
    .tx_data(tx_data0), .tx_wr(tx_wr0), .tx_full(tx_full0), .tx_busy(tx_busy0),
    .uart_tx_d_out(tx_out0), .uart_rx_d_in(rx_in0), .rx_data(rx_data0),
    .rx_frame_err(fe0), .rx_parity_err(pe0), .rx_rd(rx_rd0), .rx_empty(rx_empty0),
    .rx_overrun(ovr0), .rx_clr_ovr(clr0));

  uart_fifo_transceiver #(.CLOCK_FREQ(28'd1152000), .DATA_BITS(8), .PARITY_EN(1), .FIFO_DEPTH(4)) u_dut1 (
    .clk_int(clk), .uart_reset(uart_reset), .freq_control(freq),
    .tx_data(tx_data1), .tx_wr(tx_wr1), .tx_full(tx_full1), .tx_busy(tx_busy1),
    .uart_tx_d_out(tx_out1), .uart_rx_d_in(line1), .rx_data(rx_data1),
    .rx_frame_err(fe1), .rx_parity_err(pe1), .rx_rd(rx_rd1), .rx_empty(rx_empty1),
    .rx_overrun(ovr1), .rx_clr_ovr(clr1));

  task automatic do_reset();
    @(negedge clk);
    uart_reset = 1'b1;
    @(negedge clk);
    uart_reset = 1'b0;
    sb0.delete();
    sb1.delete();
  endtask

  task automatic drive_bit(input int sel, input logic v);
    if (sel == 0) line0 = v;
    else line1 = v;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input logic use_par,
                            input logic pbit, input logic stop_bit);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (use_par) drive_bit(sel, pbit);
    drive_bit(sel, stop_bit);
    if (sel == 0) line0 = 1'b1;
    else line1 = 1'b1;
  endtask

  // Pop n entries from the selected RX FIFO and compare against its scoreboard.
  task automatic drain(input int sel, input int n);
    logic [9:0] got, exp;
    logic       empty;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      empty = (sel == 0) ? rx_empty0 : rx_empty1;
      got   = (sel == 0) ? {rx_data0, fe0, pe0} : {rx_data1, fe1, pe1};
      checks++;
      if (empty !== 1'b0) begin
        failures++;
        $display("FAIL rx_not_empty dut%0d entry %0d got empty=%b want 0", sel, i, empty);
      end else begin
        if (sel == 0 && sb0.size() > 0) exp = sb0.pop_front();
        else if (sel == 1 && sb1.size() > 0) exp = sb1.pop_front();
        else exp = 10'bx;
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL rx_entry dut%0d entry %0d got data=%h fe=%b pe=%b want data=%h fe=%b pe=%b",
                   sel, i, got[9:2], got[1], got[0], exp[9:2], exp[1], exp[0]);
        end else begin
          $display("rx dut%0d entry %0d: data=%h fe=%b pe=%b", sel, i, got[9:2], got[1], got[0]);
        end
      end
      if (sel == 0) rx_rd0 = 1'b1;
      else rx_rd1 = 1'b1;
      @(negedge clk);
      rx_rd0 = 1'b0;
      rx_rd1 = 1'b0;
    end
    @(negedge clk);
    empty = (sel == 0) ? rx_empty0 : rx_empty1;
    got   = (sel == 0) ? {rx_data0, fe0, pe0} : {rx_data1, fe1, pe1};
    checks++;
    if (empty !== 1'b1 || got !== 10'd0) begin
      failures++;
      $display("FAIL rx_drained dut%0d got empty=%b head=%h want empty=1 head=000", sel, empty, got);
    end
    checks++;
    if ((sel == 0 ? sb0.size() : sb1.size()) != 0) begin
      failures++;
      $display("FAIL scoreboard_left dut%0d got %0d pending want 0", sel, (sel == 0 ? sb0.size() : sb1.size()));
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({tx_out0, tx_full0, tx_busy0, rx_empty0, rx_data0, fe0, pe0, ovr0} !== {4'b1001, 8'h00, 3'b000}) begin
      failures++;
      $display("FAIL reset_values got tx=%b full=%b busy=%b empty=%b data=%h fe=%b pe=%b ovr=%b want 1 0 0 1 00 0 0 0",
               tx_out0, tx_full0, tx_busy0, rx_empty0, rx_data0, fe0, pe0, ovr0);
    end
    checks++;
    if ({tx_out1, tx_busy1, rx_empty1, ovr1} !== 4'b1010) begin
      failures++;
      $display("FAIL reset_values_par got tx=%b busy=%b empty=%b ovr=%b want 1 0 1 0", tx_out1, tx_busy1, rx_empty1, ovr1);
    end
    $display("reset checked");
  endtask

  task automatic test_tx_frame();
    logic [9:0] frame;
    frame = {1'b1, 8'hA5, 1'b0};
    @(negedge clk);
    tx_data0 = 8'hA5;
    tx_wr0   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_wr0 = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (tx_out0 !== frame[(k-1)/10]) begin
        failures++;
        $display("FAIL tx_line cycle %0d got %b want %b", k, tx_out0, frame[(k-1)/10]);
      end
      if (k == 100) begin
        checks++;
        if (tx_busy0 !== 1'b1) begin
          failures++;
          $display("FAIL tx_busy_in_stop got %b want 1", tx_busy0);
        end
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (tx_busy0 !== 1'b0 || tx_out0 !== 1'b1) begin
      failures++;
      $display("FAIL tx_done got busy=%b line=%b want busy=0 line=1", tx_busy0, tx_out0);
    end
    $display("tx frame a5 checked");
  endtask

  task automatic test_back_to_back();
    logic [7:0]  vals [3];
    logic [29:0] stream;
    int w;
    vals[0] = 8'h3C; vals[1] = 8'hFF; vals[2] = 8'h00;
    stream = {1'b1, vals[2], 1'b0, 1'b1, vals[1], 1'b0, 1'b1, vals[0], 1'b0};
    loopback = 1'b1;
    do_reset();
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          tx_data0 = vals[i];
          tx_wr0   = 1'b1;
          sb0.push_back({vals[i], 2'b00});
          @(negedge clk);
        end
        tx_wr0 = 1'b0;
      end
      begin
        @(posedge clk);
        for (int k = 1; k <= 300; k++) begin
          @(posedge clk);
          #1;
          checks++;
          if (tx_out0 !== stream[(k-1)/10]) begin
            failures++;
            $display("FAIL b2b_line cycle %0d got %b want %b", k, tx_out0, stream[(k-1)/10]);
          end
        end
      end
    join
    w = 0;
    while (tx_busy0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (w >= 2000) begin
      failures++;
      $display("FAIL b2b_timeout got busy=%b after %0d cycles want 0", tx_busy0, w);
    end
    repeat (40) @(negedge clk);
    drain(0, 3);
    loopback = 1'b0;
  endtask

  task automatic test_overrun();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) sb0.push_back({8'h10 + 8'(i * 33), 2'b00});
      send_frame(0, 8'h10 + 8'(i * 33), 1'b0, 1'b0, 1'b1);
    end
    repeat (30) @(negedge clk);
    checks++;
    if (ovr0 !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set got %b want 1", ovr0);
    end
    drain(0, 4);
    checks++;
    if (ovr0 !== 1'b1) begin
      failures++;
      $display("FAIL overrun_sticky got %b want 1", ovr0);
    end
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    checks++;
    if (ovr0 !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clear got %b want 0", ovr0);
    end
    $display("overrun sequence checked");
  endtask

  task automatic test_frame_err();
    do_reset();
    sb0.push_back({8'h55, 2'b10});
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    drain(0, 1);
    line0 = 1'b0;
    repeat (3) @(negedge clk);
    line0 = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (rx_empty0 !== 1'b1) begin
      failures++;
      $display("FAIL glitch_ignored got empty=%b data=%h want empty=1", rx_empty0, rx_data0);
    end
    $display("glitch checked");
  endtask

  task automatic test_parity();
    do_reset();
    sb1.push_back({8'h01, 2'b01});
    send_frame(1, 8'h01, 1'b1, 1'b0, 1'b1);
    sb1.push_back({8'h01, 2'b00});
    send_frame(1, 8'h01, 1'b1, 1'b1, 1'b1);
    repeat (30) @(negedge clk);
    drain(1, 2);
  endtask

  task automatic test_reset_mid();
    loopback = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tx_data0 = 8'hA5 + 8'(i * 17);
      tx_wr0   = 1'b1;
    end
    @(negedge clk);
    tx_wr0 = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (tx_full0 !== 1'b1 || tx_busy0 !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset got full=%b busy=%b want full=1 busy=1", tx_full0, tx_busy0);
    end
    uart_reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (tx_out0 !== 1'b1 || tx_busy0 !== 1'b0 || tx_full0 !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got line=%b busy=%b full=%b want 1 0 0", tx_out0, tx_busy0, tx_full0);
    end
    @(negedge clk);
    uart_reset = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (tx_out0 !== 1'b1 || tx_busy0 !== 1'b0 || rx_empty0 !== 1'b1) begin
      failures++;
      $display("FAIL post_reset got line=%b busy=%b rx_empty=%b want 1 0 1", tx_out0, tx_busy0, rx_empty0);
    end
    loopback = 1'b0;
    $display("mid-frame reset checked");
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_parity();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog got timeout want completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
